data_memory_lsu: RTL

- Parametrised successor to the single-cycle word memory, serving RV32I loads and stores.
- Supports LB/LH/LW/LBU/LHU/SB/SH/SW with little-endian byte lanes, sign/zero extension, misalignment and illegal-size detection.
- Configurable depth and configurable read latency behind a valid/ready request and a one-cycle response pulse.
- Sits between the CPU datapath (ALU result as address, rs2 as store data) and backing storage; lets a multi-cycle core model slow memory.

---
 rtl/data_memory_lsu.sv | 136 +++++++++++++
 1 files changed

// File: rtl/data_memory_lsu.sv
// RV32I load/store unit over a word-addressed storage array with a valid/ready
// request, configurable read latency and a one-cycle response pulse.
module data_memory_lsu #(
   parameter int unsigned DEPTH_WORDS  = 32,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_write,
   input  logic [2:0]                  req_funct3,
   input  logic [31:0]                 req_address,
   input  logic [31:0]                 req_wdata,
   output logic                        resp_valid,
   output logic [31:0]                 resp_rdata,
   output logic                        resp_misaligned,
   output logic                        resp_illegal,
   input  logic [32*DEPTH_WORDS-1:0]   initial_values,
   output logic [32*DEPTH_WORDS-1:0]   memory_check
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam int unsigned CW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
   localparam logic [CW-1:0] COUNT_INIT = CW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [31:0]   mem [DEPTH_WORDS];
   logic [1:0]    state;
   logic [CW-1:0] count;

   logic [AW-1:0] idx;
   logic [1:0]    lane;
   logic [31:0]   old_word;
   logic [7:0]    byte_val;
   logic [15:0]   half_val;
   logic          illegal;
   logic          misaligned;
   logic [31:0]   load_data;
   logic [31:0]   store_word;
   logic          unused_addr;

   assign idx         = req_address[2 +: AW];
   assign lane        = req_address[1:0];
   assign unused_addr = ^req_address[31:AW+2];
   assign old_word    = mem[idx];
   assign byte_val    = old_word[{lane, 3'b000} +: 8];
   assign half_val    = old_word[{lane[1], 4'b0000} +: 16];

   assign req_ready  = (state == IDLE) && !reset;
   assign resp_valid = (state == RESP);

   always_comb begin
      illegal    = 1'b0;
      misaligned = 1'b0;
      if (req_write)
         illegal = (req_funct3 != 3'b000) && (req_funct3 != 3'b001) && (req_funct3 != 3'b010);
      else
         illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111);
      // Illegal takes priority so the two fault flags are mutually exclusive.
      if (!illegal)
         misaligned = ((req_funct3[1:0] == 2'b01) && lane[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (lane != 2'b00));
   end

   always_comb begin
      load_data = '0;
      if (!req_write && !illegal && !misaligned) begin
         case (req_funct3)
            3'b000:  load_data = {{24{byte_val[7]}}, byte_val};
            3'b001:  load_data = {{16{half_val[15]}}, half_val};
            3'b010:  load_data = old_word;
            3'b100:  load_data = {24'h0, byte_val};
            3'b101:  load_data = {16'h0, half_val};
            default: load_data = '0;
         endcase
      end
   end

   always_comb begin
      store_word = old_word;
      case (req_funct3[1:0])
         2'b00:   store_word[{lane, 3'b000} +: 8]     = req_wdata[7:0];
         2'b01:   store_word[{lane[1], 4'b0000} +: 16] = req_wdata[15:0];
         default: store_word = req_wdata;
      endcase
   end

   always_comb begin
      memory_check = '0;
      for (int unsigned i = 0; i < DEPTH_WORDS; i++)
         memory_check[i*32 +: 32] = mem[i];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH_WORDS; i++)
            mem[i] <= initial_values[i*32 +: 32];
         state           <= IDLE;
         count           <= '0;
         resp_rdata      <= '0;
         resp_misaligned <= 1'b0;
         resp_illegal    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (req_write && !illegal && !misaligned)
                     mem[idx] <= store_word;
                  resp_rdata      <= load_data;
                  resp_misaligned <= misaligned;
                  resp_illegal    <= illegal;
                  if (READ_LATENCY == 1) begin
                     state <= RESP;
                  end else begin
                     state <= WAIT;
                     count <= COUNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (count == '0)
                  state <= RESP;
               else
                  count <= count - CW'(1);
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
